// File: rtl/ahb_lite_master_if.sv
// rtl/ahb_lite_master_if.sv - command, response and AHB-Lite bus signals of ahb_lite_master
interface ahb_lite_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, HREADY, HRDATA,
    output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
           HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, HREADY, HRDATA,
    input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
           HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - AHB-Lite single-transfer master, address slot A overlapped with data slot D
module ahb_lite_master (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_lite_master_if.master bus
);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_BYTE     = 3'b000;
  localparam logic [2:0] SIZE_HALF     = 3'b001;
  localparam logic [2:0] SIZE_WORD     = 3'b010;

  // Address slot: its fields double as the registered HADDR/HSIZE/HWRITE outputs
  logic        a_valid_q, a_valid_d;
  logic        a_err_q,   a_err_d;
  logic [31:0] haddr_q,   haddr_d;
  logic        hwrite_q,  hwrite_d;
  logic [2:0]  hsize_q,   hsize_d;
  logic [31:0] a_wdata_q, a_wdata_d;

  logic        d_valid_q, d_valid_d;
  logic        d_err_q,   d_err_d;
  logic        d_write_q, d_write_d;
  logic [2:0]  d_size_q,  d_size_d;
  logic [1:0]  d_lane_q,  d_lane_d;
  logic [31:0] hwdata_q,  hwdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic cmd_ready;
  logic accept;
  logic d_done;

  function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: is_illegal = 1'b0;
      SIZE_HALF: is_illegal = lane[0];
      SIZE_WORD: is_illegal = (lane != 2'b00);
      default:   is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] replicate_lanes(input logic [2:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: replicate_lanes = {4{wdata[7:0]}};
      SIZE_HALF: replicate_lanes = {2{wdata[15:0]}};
      default:   replicate_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract_lanes(input logic [2:0] size, input logic [1:0] lane,
                                                input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: extract_lanes = {24'h0, shifted[7:0]};
      SIZE_HALF: extract_lanes = {16'h0, shifted[15:0]};
      default:   extract_lanes = shifted;
    endcase
  endfunction

  // A may refill whenever it is empty, even while D is stretched by wait states
  assign cmd_ready = ~a_valid_q | bus.HREADY;
  assign accept    = bus.cmd_valid & cmd_ready;
  assign d_done    = d_valid_q & bus.HREADY;

  always_comb begin
    a_valid_d = a_valid_q;
    a_err_d   = a_err_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hsize_d   = hsize_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_err_d   = d_err_q;
    d_write_d = d_write_q;
    d_size_d  = d_size_q;
    d_lane_d  = d_lane_q;
    hwdata_d  = hwdata_q;

    if (bus.HREADY) begin
      d_valid_d = a_valid_q;
      d_err_d   = a_err_q;
      d_write_d = hwrite_q;
      d_size_d  = hsize_q;
      d_lane_d  = haddr_q[1:0];
      if (a_valid_q && !a_err_q && hwrite_q) begin
        hwdata_d = replicate_lanes(hsize_q, a_wdata_q);
      end
    end

    if (accept) begin
      a_valid_d = 1'b1;
      a_err_d   = is_illegal(bus.cmd_size, bus.cmd_addr[1:0]);
      haddr_d   = bus.cmd_addr;
      hwrite_d  = bus.cmd_write;
      hsize_d   = bus.cmd_size;
      a_wdata_d = bus.cmd_wdata;
    end else if (bus.HREADY) begin
      a_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = d_done;
    rsp_write_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    if (d_done) begin
      rsp_write_d = d_write_q;
      rsp_err_d   = d_err_q;
      if (!d_write_q && !d_err_q) begin
        rsp_rdata_d = extract_lanes(d_size_q, d_lane_q, bus.HRDATA);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_err_q     <= 1'b0;
      haddr_q     <= 32'h0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      a_wdata_q   <= 32'h0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_write_q   <= 1'b0;
      d_size_q    <= 3'b000;
      d_lane_q    <= 2'b00;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_err_q     <= a_err_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
      d_write_q   <= d_write_d;
      d_size_q    <= d_size_d;
      d_lane_q    <= d_lane_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Illegal commands still walk through A, but never show a NONSEQ on the bus
  assign bus.HTRANS    = (a_valid_q && !a_err_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = haddr_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb/tb_ahb_lite_master.sv - scoreboard bench for ahb_lite_master
module tb_ahb_lite_master;
  logic HCLK;
  logic HRESET;
  int   checks;
  int   errors;

  ahb_lite_master_if bus ();

  ahb_lite_master dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Entries are {write, err, rdata}
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  always @(negedge HCLK) begin
    if (bus.rsp_valid === 1'b1) got_q.push_back({bus.rsp_write, bus.rsp_err, bus.rsp_rdata});
  end

  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [31:0] a, input logic w,
                           input logic [2:0] s, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h0;
    drive_cmd(1'b1, 32'hFFFF_FFF0, 1'b1, 3'b010, 32'h1234_5678);
    tick();
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_write !== 1'b0) begin errors++; $display("FAIL reset_rsp_write got %0b exp 0", bus.rsp_write); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b exp 0", bus.rsp_err); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
    checks++; if (bus.HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr got %h exp 0", bus.HADDR); end
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans got %b exp 00", bus.HTRANS); end
    checks++; if (bus.HSIZE !== 3'b000) begin errors++; $display("FAIL reset_hsize got %b exp 000", bus.HSIZE); end
    checks++; if (bus.HWRITE !== 1'b0) begin errors++; $display("FAIL reset_hwrite got %b exp 0", bus.HWRITE); end
    checks++; if (bus.HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata got %h exp 0", bus.HWDATA); end
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    HRESET = 1'b0;
    tick();
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL reset_idle_htrans got %b exp 00", bus.HTRANS); end
  endtask

  task automatic test_single_read();
    logic [33:0] e, g;
    drive_cmd(1'b1, 32'h0000_0010, 1'b0, 3'b010, 32'h0);
    bus.HRDATA = 32'hDEAD_BEEF;
    exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL single_cmd_ready got %b exp 1", bus.cmd_ready); end
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    checks++; if (bus.HTRANS !== 2'b10) begin errors++; $display("FAIL single_htrans got %b exp 10", bus.HTRANS); end
    checks++; if (bus.HWRITE !== 1'b0) begin errors++; $display("FAIL single_hwrite got %b exp 0", bus.HWRITE); end
    checks++; if (bus.HADDR !== 32'h10) begin errors++; $display("FAIL single_haddr got %h exp 10", bus.HADDR); end
    checks++; if (bus.HSIZE !== 3'b010) begin errors++; $display("FAIL single_hsize got %b exp 010", bus.HSIZE); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early got %b exp 0", bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_latency got %b exp 1", bus.rsp_valid); end
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL single_rsp got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [33:0] e, g;
    drive_cmd(1'b1, 32'h20, 1'b1, 3'b010, 32'h1122_3344);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick();
    checks++; if (bus.HADDR !== 32'h20) begin errors++; $display("FAIL b2b_haddr0 got %h exp 20", bus.HADDR); end
    checks++; if (bus.HWRITE !== 1'b1) begin errors++; $display("FAIL b2b_hwrite0 got %b exp 1", bus.HWRITE); end
    drive_cmd(1'b1, 32'h24, 1'b0, 3'b010, 32'h0);
    bus.HRDATA = 32'hCAFE_F00D;
    exp_q.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    checks++; if (bus.HADDR !== 32'h24) begin errors++; $display("FAIL b2b_haddr1 got %h exp 24", bus.HADDR); end
    checks++; if (bus.HTRANS !== 2'b10) begin errors++; $display("FAIL b2b_htrans1 got %b exp 10", bus.HTRANS); end
    checks++; if (bus.HWDATA !== 32'h1122_3344) begin errors++; $display("FAIL b2b_hwdata got %h exp 11223344", bus.HWDATA); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b1) begin errors++; $display("FAIL b2b_rsp0 got v%b w%b exp v1 w1", bus.rsp_valid, bus.rsp_write); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_write !== 1'b0) begin errors++; $display("FAIL b2b_rsp1 got v%b w%b exp v1 w0", bus.rsp_valid, bus.rsp_write); end
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_rsp got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wait_states();
    logic [33:0] e, g;
    bus.HREADY = 1'b1;
    drive_cmd(1'b1, 32'h3C, 1'b1, 3'b010, 32'hA5A5_5A5A);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick();
    drive_cmd(1'b1, 32'h40, 1'b0, 3'b010, 32'h0);
    exp_q.push_back({1'b0, 1'b0, 32'h0102_0304});
    tick();
    drive_cmd(1'b1, 32'h44, 1'b1, 3'b010, 32'h5566_7788);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick();
    drive_cmd(1'b1, 32'h48, 1'b0, 3'b010, 32'h0);
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D});
    bus.HREADY = 1'b0;
    bus.HRDATA = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL ws_cmd_ready0 got %b exp 0", bus.cmd_ready); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.HADDR !== 32'h44) begin errors++; $display("FAIL ws_haddr_c%0d got %h exp 44", c, bus.HADDR); end
      checks++; if (bus.HTRANS !== 2'b10) begin errors++; $display("FAIL ws_htrans_c%0d got %b exp 10", c, bus.HTRANS); end
      checks++; if (bus.HWDATA !== 32'hA5A5_5A5A) begin errors++; $display("FAIL ws_hwdata_c%0d got %h exp a5a55a5a", c, bus.HWDATA); end
      tick();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_rsp_stall_c%0d got %b exp 0", c, bus.rsp_valid); end
      checks++; if (bus.cmd_ready !== bus.HREADY && c == 0) begin errors++; $display("FAIL ws_cmd_ready1 got %b exp 0", bus.cmd_ready); end
    end
    checks++; if (bus.HADDR !== 32'h44) begin errors++; $display("FAIL ws_haddr_end got %h exp 44", bus.HADDR); end
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h0102_0304;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ws_cmd_ready_resume got %b exp 1", bus.cmd_ready); end
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    bus.HRDATA = 32'h0BAD_F00D;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0102_0304) begin errors++; $display("FAIL ws_rsp_delayed got v%b %h exp v1 01020304", bus.rsp_valid, bus.rsp_rdata); end
    checks++; if (bus.HADDR !== 32'h48) begin errors++; $display("FAIL ws_haddr_next got %h exp 48", bus.HADDR); end
    checks++; if (bus.HWDATA !== 32'h5566_7788) begin errors++; $display("FAIL ws_hwdata_next got %h exp 55667788", bus.HWDATA); end
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ws_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL ws_rsp got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_byte_lanes();
    logic [33:0] e, g;
    bus.HRDATA = 32'hAABB_CCDD;
    drive_cmd(1'b1, 32'h103, 1'b1, 3'b000, 32'h1234_5633);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick();
    checks++; if (bus.HSIZE !== 3'b000) begin errors++; $display("FAIL lane_hsize_byte got %b exp 000", bus.HSIZE); end
    checks++; if (bus.HADDR !== 32'h103) begin errors++; $display("FAIL lane_haddr got %h exp 103", bus.HADDR); end
    drive_cmd(1'b1, 32'h102, 1'b0, 3'b000, 32'h0);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_00BB});
    tick();
    checks++; if (bus.HWDATA !== 32'h3333_3333) begin errors++; $display("FAIL lane_hwdata_byte got %h exp 33333333", bus.HWDATA); end
    drive_cmd(1'b1, 32'h102, 1'b0, 3'b001, 32'h0);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_AABB});
    tick();
    drive_cmd(1'b1, 32'h106, 1'b1, 3'b001, 32'hFFFF_1234);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick();
    checks++; if (bus.HSIZE !== 3'b001) begin errors++; $display("FAIL lane_hsize_half got %b exp 001", bus.HSIZE); end
    drive_cmd(1'b1, 32'h101, 1'b0, 3'b000, 32'h0);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_00CC});
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    checks++; if (bus.HWDATA !== 32'h1234_1234) begin errors++; $display("FAIL lane_hwdata_half got %h exp 12341234", bus.HWDATA); end
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL lane_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL lane_rsp got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_illegal();
    logic [33:0] e, g;
    bus.HRDATA = 32'h600D_CAFE;
    drive_cmd(1'b1, 32'h80, 1'b1, 3'b010, 32'h0F0E_0D0C);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    tick();
    checks++; if (bus.HTRANS !== 2'b10) begin errors++; $display("FAIL ill_htrans_legal got %b exp 10", bus.HTRANS); end
    drive_cmd(1'b1, 32'h2, 1'b0, 3'b010, 32'h0);
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    tick();
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL ill_htrans_word got %b exp 00", bus.HTRANS); end
    checks++; if (bus.HWDATA !== 32'h0F0E_0D0C) begin errors++; $display("FAIL ill_hwdata_legal got %h exp 0f0e0d0c", bus.HWDATA); end
    drive_cmd(1'b1, 32'h81, 1'b1, 3'b001, 32'h0000_BEEF);
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    tick();
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL ill_htrans_half got %b exp 00", bus.HTRANS); end
    drive_cmd(1'b1, 32'h0, 1'b0, 3'b011, 32'h0);
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    tick();
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL ill_htrans_size got %b exp 00", bus.HTRANS); end
    checks++; if (bus.HWDATA !== 32'h0F0E_0D0C) begin errors++; $display("FAIL ill_hwdata_hold got %h exp 0f0e0d0c", bus.HWDATA); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL ill_rsp_err got v%b e%b %h exp v1 e1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    drive_cmd(1'b1, 32'h84, 1'b0, 3'b010, 32'h0);
    exp_q.push_back({1'b0, 1'b0, 32'h600D_CAFE});
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h84) begin errors++; $display("FAIL ill_neighbour got %b %h exp 10 84", bus.HTRANS, bus.HADDR); end
    tick();
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL ill_htrans_idle got %b exp 00", bus.HTRANS); end
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) tick();
    repeat (2) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ill_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL ill_rsp got %h exp %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    bus.HREADY = 1'b1;
    drive_cmd(1'b1, 32'h200, 1'b1, 3'b010, 32'h7777_7777);
    tick();
    drive_cmd(1'b1, 32'h204, 1'b0, 3'b010, 32'h0);
    tick();
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    bus.HREADY = 1'b0;
    checks++; if (bus.HTRANS !== 2'b10) begin errors++; $display("FAIL rst_pre_htrans got %b exp 10", bus.HTRANS); end
    checks++; if (bus.HWDATA !== 32'h7777_7777) begin errors++; $display("FAIL rst_pre_hwdata got %h exp 77777777", bus.HWDATA); end
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got %b exp 00", bus.HTRANS); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata got %h exp 0", bus.HWDATA); end
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", bus.cmd_ready); end
    bus.HREADY = 1'b1;
    repeat (6) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_no_rsp got %0d exp 0", got_q.size()); end
    got_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    HRESET = 1'b1;
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'h0;
    drive_cmd(1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
